mimo_dsp: RTL and testbench

- N-lane fixed MIMO mixing stage for a parallel sample bus.
- Each cycle it takes one signed sample per lane and applies a normalized N-point Walsh-Hadamard transform (Sylvester ordering) across the lanes.
- Each result is divided by N using an arithmetic right shift, and the transformed vector is presented on the output bus.
- Sits between a parallel front-end and downstream per-lane processing; it has no handshake and is always streaming.

---
 rtl/mimo_dsp_pkg.sv | 39 +++
 rtl/mimo_dsp_butterfly.sv | 18 +
 rtl/mimo_dsp.sv | 74 +++++++
 tb/tb_mimo_dsp.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mimo_dsp_pkg.sv
// Shared sizing helpers for the MIMO Walsh-Hadamard mixing stage.
//   DEF_N / DEF_DATA_WIDTH : default lane count and lane sample width
//   log2n()        : number of butterfly stages for N lanes
//   sum_width()    : full-precision sum width (DATA_WIDTH + log2(N))
//   lane_offset()  : bit offset of a lane inside a packed lane vector
//   stage_offset() : bit offset of a stage inside the packed butterfly network
package mimo_dsp_pkg;

  localparam int unsigned DEF_N          = 4;
  localparam int unsigned DEF_DATA_WIDTH = 16;

  // Stage count of the radix-2 network.
  function automatic int unsigned log2n(input int unsigned n);
    return $clog2(n);
  endfunction

  // SUM_W: one extra bit per stage, so the final sum can never overflow.
  function automatic int unsigned sum_width(input int unsigned data_width,
                                            input int unsigned n);
    return data_width + $clog2(n);
  endfunction

  // Lane index to bit offset for a packed vector of equal-width lanes.
  function automatic int unsigned lane_offset(input int unsigned lane,
                                              input int unsigned width);
    return lane * width;
  endfunction

  // Stage s holds N lanes of (data_width + s) bits; stages are packed back to
  // back, so the offset of stage s is N * sum_{t<s} (data_width + t).
  function automatic int unsigned stage_offset(input int unsigned stage,
                                               input int unsigned data_width,
                                               input int unsigned n);
    int unsigned tri_sum;
    tri_sum = (stage * (stage - 1)) / 2;
    return n * (stage * data_width + tri_sum);
  endfunction

endpackage

// File: rtl/mimo_dsp_butterfly.sv
// Radix-2 add/subtract butterfly, purely combinational, one bit of growth.
//   a, b : signed IN_W-bit operands
//   sum  : a + b, signed IN_W+1 bits
//   diff : a - b, signed IN_W+1 bits
module mimo_dsp_butterfly #(
  parameter int unsigned IN_W = 16
) (
  input  logic signed [IN_W-1:0] a,
  input  logic signed [IN_W-1:0] b,
  output logic signed [IN_W:0]   sum,
  output logic signed [IN_W:0]   diff
);

  // Sign-extend both operands before combining so neither result can wrap.
  assign sum  = (IN_W+1)'(a) + (IN_W+1)'(b);
  assign diff = (IN_W+1)'(a) - (IN_W+1)'(b);

endmodule

// File: rtl/mimo_dsp.sv
// N-lane normalized Walsh-Hadamard mixing stage (Sylvester/natural ordering).
// Two register stages: input register x_q, then data_out holding the transform
// of x_q divided by N with an arithmetic (floor) shift. No handshake.
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset, clears both registers
//   data_in  : N packed signed lanes, lane 0 in the LSBs
//   data_out : N packed signed transformed lanes, same packing
module mimo_dsp
  import mimo_dsp_pkg::*;
#(
  parameter int unsigned N          = DEF_N,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N*DATA_WIDTH-1:0] data_in,
  output logic [N*DATA_WIDTH-1:0] data_out
);

  localparam int unsigned LOG2N    = log2n(N);
  localparam int unsigned SUM_W    = sum_width(DATA_WIDTH, N);
  localparam int unsigned VEC_W    = N * DATA_WIDTH;
  localparam int unsigned LAST_OFF = stage_offset(LOG2N, DATA_WIDTH, N);
  localparam int unsigned NET_W    = stage_offset(LOG2N + 1, DATA_WIDTH, N);

  logic [VEC_W-1:0] x_q;
  logic [NET_W-1:0] net;   // all stages of the butterfly network, packed
  logic [VEC_W-1:0] y_c;   // normalized transform of x_q

  // Stage 0 of the network is the registered input vector.
  assign net[VEC_W-1:0] = x_q;

  // Butterfly network: stage s pairs lanes j and j + 2^s (bit s of j clear).
  // Writing the sum back to lane j and the difference to lane j + 2^s yields
  // the natural-order Hadamard matrix, sign = (-1)^popcount(k & i).
  for (genvar s = 0; s < LOG2N; s++) begin : g_stage
    localparam int unsigned H       = 1 << s;
    localparam int unsigned IN_W    = DATA_WIDTH + s;
    localparam int unsigned IN_OFF  = stage_offset(s, DATA_WIDTH, N);
    localparam int unsigned OUT_OFF = stage_offset(s + 1, DATA_WIDTH, N);

    for (genvar p = 0; p < N / 2; p++) begin : g_bfly
      localparam int unsigned J = (p / H) * 2 * H + (p % H);
      localparam int unsigned K = J + H;

      mimo_dsp_butterfly #(
        .IN_W (IN_W)
      ) u_bfly (
        .a    (net[IN_OFF  + lane_offset(J, IN_W)     +: IN_W]),
        .b    (net[IN_OFF  + lane_offset(K, IN_W)     +: IN_W]),
        .sum  (net[OUT_OFF + lane_offset(J, IN_W + 1) +: IN_W + 1]),
        .diff (net[OUT_OFF + lane_offset(K, IN_W + 1) +: IN_W + 1])
      );
    end
  end

  // Divide by N with floor rounding; the quotient always fits DATA_WIDTH bits.
  for (genvar k = 0; k < N; k++) begin : g_norm
    assign y_c[lane_offset(k, DATA_WIDTH) +: DATA_WIDTH] =
      DATA_WIDTH'($signed(net[LAST_OFF + lane_offset(k, SUM_W) +: SUM_W]) >>> LOG2N);
  end

  // Input and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q      <= '0;
      data_out <= '0;
    end else begin
      x_q      <= data_in;
      data_out <= y_c;
    end
  end

endmodule

// File: tb/tb_mimo_dsp.sv
// Self-checking bench for mimo_dsp (N = 4, DATA_WIDTH = 16): directed cases,
// mid-stream asynchronous reset, then a randomized stream checked against a
// matrix-form Hadamard reference model.
module tb_mimo_dsp;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned W  = N * DW;
  localparam int unsigned SH = $clog2(N);

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] data_in;
  logic [W-1:0] data_out;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] exp_q[$];

  mimo_dsp #(
    .N          (N),
    .DATA_WIDTH (DW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .data_in  (data_in),
    .data_out (data_out)
  );

  always #5 clk = ~clk;

  // Reference: y[k] = floor(sum_i s(k,i) * x[i] / N), s = (-1)^popcount(k&i).
  function automatic logic [W-1:0] model(input logic [W-1:0] v);
    logic [W-1:0] r;
    logic [DW-1:0] lane;
    int acc;
    int xi;
    r = '0;
    for (int k = 0; k < int'(N); k++) begin
      acc = 0;
      for (int i = 0; i < int'(N); i++) begin
        lane = v[i*DW +: DW];
        xi   = int'($signed(lane));
        if (($countones(k & i) % 2) == 0) acc = acc + xi;
        else                               acc = acc - xi;
      end
      acc = acc >>> SH;
      r[k*DW +: DW] = acc[DW-1:0];
    end
    return r;
  endfunction

  function automatic logic [W-1:0] pack4(input logic [15:0] l3, input logic [15:0] l2,
                                         input logic [15:0] l1, input logic [15:0] l0);
    return {l3, l2, l1, l0};
  endfunction

  function automatic logic [15:0] rand_lane();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'hFFFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  // Advance one rising edge and settle 1 time unit past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [W-1:0] expected);
    checks++;
    assert (data_out === expected)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, data_out, expected);
    end
  endtask

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] va;

    // Reset hold with a live input bus.
    rst     = 1'b1;
    data_in = pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004);
    #2;
    check("reset_idle", '0);
    tick();
    tick();
    check("reset_hold", '0);

    // Release between edges: first edge only loads x, second shows result.
    rst = 1'b0;
    tick();
    check("latency_edge1", '0);
    tick();
    check("latency_edge2", 64'h0000_0001_0000_0002);
    check("latency_model", model(data_in));

    // Back-to-back vectors.
    v  = pack4(16'h0010, 16'h0020, 16'h0030, 16'h0040);
    va = pack4(16'h0A0A, 16'h0B0B, 16'h0C0C, 16'h0D0D);
    data_in = v;
    tick();
    data_in = va;
    tick();
    check("stream_a", 64'h0000_0010_0008_0028);
    check("stream_a_model", model(v));
    tick();
    check("stream_b", 64'h0000_0101_0080_0B8B);
    check("stream_b_model", model(va));

    // Floor rounding of a small negative value.
    data_in = pack4(16'h0000, 16'h0000, 16'h0000, 16'hFFFF);
    tick();
    tick();
    check("floor_neg1", 64'hFFFF_FFFF_FFFF_FFFF);

    // Extremes.
    data_in = {4{16'h8000}};
    tick();
    tick();
    check("all_min", 64'h0000_0000_0000_8000);
    data_in = {4{16'h7FFF}};
    tick();
    tick();
    check("all_max", 64'h0000_0000_0000_7FFF);

    // Asynchronous reset mid-cycle while output is nonzero.
    #2;
    rst = 1'b1;
    #1;
    check("async_clear", '0);
    v       = pack4(16'h1234, 16'hFEDC, 16'h8001, 16'h7F00);
    data_in = v;
    #1;
    rst = 1'b0;
    tick();
    check("post_reset_edge1", '0);
    tick();
    check("post_reset_edge2", model(v));

    // Randomized stream against the reference model.
    exp_q.delete();
    for (int n = 0; n < 400; n++) begin
      v = pack4(rand_lane(), rand_lane(), rand_lane(), rand_lane());
      data_in = v;
      exp_q.push_back(model(v));
      tick();
      if (exp_q.size() == 2) check("random_stream", exp_q.pop_front());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
